kim_led_refresh: RTL



---
 rtl/kim_led_refresh.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/kim_led_refresh.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kim_led_refresh : KIM-1 digit latches with autonomous LED rescan   |
// | Define LED_DECAY_EN to blank digits the CPU stops refreshing.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module kim_led_refresh #(
   parameter int NUM_DIGITS     = 6,
   parameter int SEG_W          = 7,
   parameter int SCAN_DIV       = 2000,
   parameter int BLANK_CYCLES   = 50,
   parameter int CAPTURE_STABLE = 100,
   parameter int HOLD_FRAMES    = 50
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_DIGITS-1:0] dig_in,
   input  logic [SEG_W-1:0]      seg_in,
   output logic [NUM_DIGITS-1:0] LED_DIG,
   output logic [SEG_W-1:0]      LED_SEG,
   output logic                  frame_tick
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int STAB_W = $clog2(CAPTURE_STABLE + 1);
   localparam int REF_W  = NUM_DIGITS + SEG_W;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STABLE = 1'b1;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [STAB_W-1:0] STAB_FULL = STAB_W'(CAPTURE_STABLE);

   if (SCAN_DIV <= BLANK_CYCLES || CAPTURE_STABLE < 1 || HOLD_FRAMES < 1 || NUM_DIGITS < 1)
   begin : g_param_check
      $error("kim_led_refresh: illegal parameter combination");
   end

   // ------------------------------------------------------------------
   // Strobe qualification and capture FSM
   // ------------------------------------------------------------------
   logic [0:0]            state_q, state_d;
   logic [STAB_W-1:0]     stab_q, stab_d;
   logic [REF_W-1:0]      ref_q, ref_d;
   logic [REF_W-1:0]      strobe;
   logic [NUM_DIGITS-1:0] sel;
   logic                  strobe_valid;
   logic                  cap_en;

   assign strobe       = {dig_in, seg_in};
   assign sel          = ~dig_in;
   // exactly one digit line pulled low
   assign strobe_valid = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);

   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      ref_d   = ref_q;
      case (state_q)
         S_IDLE: begin
            if (strobe_valid) begin
               state_d = S_STABLE;
               stab_d  = STAB_W'(1);
               ref_d   = strobe;
            end
         end
         default: begin
            if (strobe == ref_q) begin
               if (stab_q != STAB_FULL) begin
                  stab_d = stab_q + STAB_W'(1);
               end
            end else if (strobe_valid) begin
               stab_d = STAB_W'(1);
               ref_d  = strobe;
            end else begin
               state_d = S_IDLE;
               stab_d  = '0;
            end
         end
      endcase
   end

   // Fires only on the edge the counter arrives at full, never while parked there.
   always_comb begin
      cap_en = 1'b0;
      case (state_q)
         S_IDLE:  cap_en = (state_d == S_STABLE) && (stab_d == STAB_FULL);
         default: cap_en = (state_d == S_STABLE) && (stab_d == STAB_FULL) &&
                           ((stab_q != STAB_FULL) || (ref_d != ref_q));
      endcase
   end

   // ------------------------------------------------------------------
   // Scanner
   // ------------------------------------------------------------------
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              frame_tick_q, frame_tick_d;

   always_comb begin
      slot_d       = slot_q + SLOT_W'(1);
      idx_d        = idx_q;
      frame_tick_d = 1'b0;
      if (slot_q == SLOT_LAST) begin
         slot_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            frame_tick_d = 1'b1;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-digit pattern latches and lit status
   // ------------------------------------------------------------------
   logic [SEG_W-1:0]      pat_q [NUM_DIGITS];
   logic [SEG_W-1:0]      pat_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] lit;

`ifdef LED_DECAY_EN
   localparam int AGE_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [AGE_W-1:0] AGE_FULL = AGE_W'(HOLD_FRAMES);

   logic [AGE_W-1:0] age_q [NUM_DIGITS];
   logic [AGE_W-1:0] age_d [NUM_DIGITS];

   // a capture overrides a same-cycle frame decrement
   always_comb begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
         pat_d[d] = pat_q[d];
         age_d[d] = age_q[d];
         lit[d]   = (age_q[d] != '0);
         if (frame_tick_q && (age_q[d] != '0)) begin
            age_d[d] = age_q[d] - AGE_W'(1);
         end
         if (cap_en && sel[d]) begin
            pat_d[d] = seg_in;
            age_d[d] = AGE_FULL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            age_q[d] <= '0;
         end
      end else begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            age_q[d] <= age_d[d];
         end
      end
   end
`else
   logic [NUM_DIGITS-1:0] vld_q, vld_d;

   always_comb begin
      vld_d = vld_q;
      lit   = vld_q;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         pat_d[d] = pat_q[d];
         if (cap_en && sel[d]) begin
            pat_d[d] = seg_in;
            vld_d[d] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Pin drive: registered from the next scan position so the blank gap
   // lines up exactly with slot cycles 0..BLANK_CYCLES-1.
   // ------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] led_dig_q, led_dig_d;
   logic [SEG_W-1:0]      led_seg_q, led_seg_d;

   always_comb begin
      led_dig_d = '1;
      led_seg_d = '1;
      if (slot_d >= BLANK_END) begin
         led_dig_d = ~(NUM_DIGITS'(1) << idx_d);
         if (lit[idx_d]) begin
            led_seg_d = pat_q[idx_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         stab_q       <= '0;
         ref_q        <= '1;
         slot_q       <= '0;
         idx_q        <= '0;
         frame_tick_q <= 1'b0;
         led_dig_q    <= '1;
         led_seg_q    <= '1;
         for (int d = 0; d < NUM_DIGITS; d++) begin
            pat_q[d] <= '1;
         end
      end else begin
         state_q      <= state_d;
         stab_q       <= stab_d;
         ref_q        <= ref_d;
         slot_q       <= slot_d;
         idx_q        <= idx_d;
         frame_tick_q <= frame_tick_d;
         led_dig_q    <= led_dig_d;
         led_seg_q    <= led_seg_d;
         for (int d = 0; d < NUM_DIGITS; d++) begin
            pat_q[d] <= pat_d[d];
         end
      end
   end

   assign LED_DIG    = led_dig_q;
   assign LED_SEG    = led_seg_q;
   assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
